// File: rtl/keypad_entry_ctrl_if.sv
// Keypad controller bus: raw key lines in,
// register-file write, commit and error pulses out.
interface keypad_entry_ctrl_if;
  logic [11:0] key_in;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [6:0]  wr_data;
  logic        out_en;
  logic        key_err;
  logic [2:0]  ptr;

  modport master (
    output key_in,
    input  wr_en, wr_addr, wr_data,
    input  out_en, key_err, ptr
  );

  modport slave (
    input  key_in,
    output wr_en, wr_addr, wr_data,
    output out_en, key_err, ptr
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad sequencer: sync, debounce, one action per
// press into the 8-digit display register file.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  keypad_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, DEB, ACT, WREL
  } state_t;

  localparam logic [7:0] LP_LAST =
    8'(DEBOUNCE_CYCLES - 1);

  state_t      r_state, w_nxt;
  logic [11:0] r_s1, r_key_s;
  logic [11:0] r_key_q, w_key_q;
  logic [7:0]  r_cnt, w_cnt;
  logic [2:0]  r_ptr, w_ptr;
  logic        r_wr_en, w_wr_en;
  logic [6:0]  r_wr_data, w_wr_data;
  logic        r_out_en, w_out_en;
  logic        r_key_err, w_key_err;
  logic        w_digit;

  function automatic logic [6:0] seg(
    input logic [9:0] k
  );
    logic [6:0] s;
    s = 7'h00;
    unique case (1'b1)
      k[0]: s = 7'h3F;
      k[1]: s = 7'h06;
      k[2]: s = 7'h5B;
      k[3]: s = 7'h4F;
      k[4]: s = 7'h66;
      k[5]: s = 7'h6D;
      k[6]: s = 7'h7D;
      k[7]: s = 7'h07;
      k[8]: s = 7'h7F;
      k[9]: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign w_digit = (r_key_q[11:10] == 2'b00)
                 && $onehot(r_key_q[9:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_key_s <= '0;
    end else begin
      r_s1    <= bus.key_in;
      r_key_s <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_key_q   = r_key_q;
    w_ptr     = r_ptr;
    w_wr_en   = 1'b0;
    w_wr_data = 7'h00;
    w_out_en  = 1'b0;
    w_key_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_key_s != 12'h000) begin
          w_key_q = r_key_s;
          w_cnt   = 8'd0;
          w_nxt   = DEB;
        end
      end
      DEB: begin
        if (r_key_s != r_key_q) begin
          w_nxt = IDLE;
        end else if (r_cnt == LP_LAST) begin
          // pulses are registered so they line up with ACT
          w_nxt = ACT;
          if (w_digit) begin
            w_wr_en   = 1'b1;
            w_wr_data = seg(r_key_q[9:0]);
          end else if (r_key_q == 12'h400) begin
            w_out_en = 1'b1;
          end else if (r_key_q != 12'h800) begin
            w_key_err = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      ACT: begin
        w_nxt = WREL;
        w_cnt = 8'd0;
        if (r_key_q == 12'h800)
          w_ptr = r_ptr + 3'd1;
      end
      WREL: begin
        if (r_key_s != 12'h000) begin
          w_cnt = 8'd0;
        end else if (r_cnt == LP_LAST) begin
          w_nxt = IDLE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_key_q   <= '0;
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_out_en  <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt;
      r_key_q   <= w_key_q;
      r_ptr     <= w_ptr;
      r_wr_en   <= w_wr_en;
      r_wr_data <= w_wr_data;
      r_out_en  <= w_out_en;
      r_key_err <= w_key_err;
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_ptr;
  assign bus.wr_data = r_wr_data;
  assign bus.out_en  = r_out_en;
  assign bus.key_err = r_key_err;
  assign bus.ptr     = r_ptr;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed and random
// presses against a streak-counting reference model.
module tb_keypad_entry_ctrl;

  localparam int D = 4;
  localparam logic [6:0] SEG [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if kif();

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  int errs = 0;
  int checks = 0;
  int n_wr = 0;
  int n_oe = 0;
  int n_err = 0;

  logic [11:0] p1, p2, cand;
  int          n, z;
  bit          rel, pend;
  logic [2:0]  mptr;
  logic        e_wr, e_oe, e_err;
  logic [6:0]  e_data;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {16'h0, kif.wr_en, kif.out_en,
            kif.key_err, kif.wr_addr,
            kif.wr_data, kif.ptr};
  endfunction

  function automatic logic [31:0] expv();
    return {16'h0, e_wr, e_oe, e_err, mptr,
            e_data, mptr};
  endfunction

  task automatic m_reset();
    p1 = '0; p2 = '0; cand = '0;
    n = 0; z = 0; rel = 0; pend = 0;
    mptr = '0;
    e_wr = 0; e_oe = 0; e_err = 0;
    e_data = '0;
  endtask

  task automatic m_act(input logic [11:0] v);
    if (v[11:10] == 2'b00
        && $countones(v[9:0]) == 1) begin
      e_wr = 1;
      for (int i = 0; i < 10; i++)
        if (v[i]) e_data = SEG[i];
    end else if (v == 12'h800) begin
      pend = 1;
    end else if (v == 12'h400) begin
      e_oe = 1;
    end else begin
      e_err = 1;
    end
  endtask

  // A press is acted on after D+1 equal samples; a
  // sample that breaks a streak is consumed, and
  // release needs D zero samples after the ACT cycle.
  task automatic m_step(input logic [11:0] kin);
    logic [11:0] ks;
    ks = p2; p2 = p1; p1 = kin;
    if (pend) begin mptr++; pend = 0; end
    e_wr = 0; e_oe = 0; e_err = 0;
    e_data = '0;
    if (rel) begin
      if (z < 0) z = 0;
      else if (ks != 0) z = 0;
      else begin
        z++;
        if (z == D) begin rel = 0; n = 0; end
      end
    end else if (n > 0 && ks != cand) begin
      n = 0;
    end else if (ks == 0) begin
      n = 0;
    end else begin
      if (n == 0) cand = ks;
      n++;
      if (n == D + 1) begin
        m_act(cand);
        rel = 1; z = -1;
      end
    end
  endtask

  task automatic tick(input logic [11:0] kin);
    @(negedge clk);
    chk("cycle", obs(), expv());
    n_wr  += int'(kif.wr_en);
    n_oe  += int'(kif.out_en);
    n_err += int'(kif.key_err);
    kif.key_in = kin;
    @(posedge clk);
    if (rst) m_step(kin);
    else     m_reset();
  endtask

  task automatic press(
    input logic [11:0] k,
    input int hold,
    input int gap
  );
    repeat (hold) tick(k);
    repeat (gap) tick(12'h000);
  endtask

  task automatic do_reset(input logic [11:0] k);
    #3 rst = 1'b0;
    m_reset();
    #1 chk("rst_async", obs(), 32'h0);
    repeat (3) tick(k);
    #2 rst = 1'b1;
  endtask

  task automatic clr_cnt();
    n_wr = 0; n_oe = 0; n_err = 0;
  endtask

  initial begin
    logic [11:0] k;
    int sel;
    kif.key_in = '0;
    m_reset();
    #1 chk("rst_state", obs(), 32'h0);
    repeat (3) tick(12'h000);
    #2 rst = 1'b1;

    clr_cnt();
    press(12'h080, 20, 10);
    chk("dig7_cnt", 32'(n_wr), 32'd1);

    clr_cnt();
    press(12'h020, 5, 0);
    do_reset(12'h020);
    chk("rst_ptr", 32'(kif.ptr), 32'd0);
    press(12'h020, 10, 10);
    chk("rst_redeb", 32'(n_wr), 32'd1);

    for (int i = 0; i < 8; i++) begin
      press(12'h800, 7, 8);
      chk("ptr_step", 32'(kif.ptr),
          32'((i + 1) % 8));
    end
    clr_cnt();
    press(12'h008, 8, 8);
    chk("wrap_wr", 32'(n_wr), 32'd1);

    clr_cnt();
    press(12'h400, 8, 8);
    chk("commit_oe", 32'(n_oe), 32'd1);
    chk("commit_wr", 32'(n_wr), 32'd0);

    clr_cnt();
    for (int i = 0; i < 5; i++) begin
      tick(12'h004); tick(12'h004);
      tick(12'h000);
    end
    press(12'h004, 12, 10);
    chk("bounce_wr", 32'(n_wr), 32'd1);

    clr_cnt();
    press(12'h003, 10, 10);
    chk("multi_err", 32'(n_err), 32'd1);
    chk("multi_wr", 32'(n_wr), 32'd0);

    clr_cnt();
    press(12'h800, 9, 0);
    press(12'hA00, 10, 0);
    press(12'h200, 6, 10);
    chk("wrel_wr", 32'(n_wr), 32'd0);
    press(12'h200, 8, 8);
    chk("repress_wr", 32'(n_wr), 32'd1);

    for (int e = 0; e < 60; e++) begin
      sel = int'($urandom_range(0, 11));
      if (sel <= 5)
        k = 12'(1 << $urandom_range(0, 9));
      else if (sel == 6) k = 12'h800;
      else if (sel == 7) k = 12'h400;
      else
        k = 12'(1 << $urandom_range(0, 11))
          | 12'(1 << $urandom_range(0, 11));
      repeat ($urandom_range(1, 9)) begin
        if ($urandom_range(0, 7) == 0)
          tick(12'h000);
        else
          tick(k);
      end
      if ($urandom_range(0, 15) == 0)
        do_reset(k);
      press(12'h000, 0,
            int'($urandom_range(0, 9)));
    end
    press(12'h000, 0, 12);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller between the 12-line keypad and the 8-digit display register file. Synchronizes and debounces raw keypad lines and produces one action per key press. Digit keys write a 7-segment pattern into the register-file slot selected by an internal pointer, `#` advances the pointer, and `*` issues a one-cycle commit pulse to the display path. A second press is not accepted until the key has been released and the release has been debounced.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required for press and for release; legal range 1..255.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_in` in 12: raw keypad lines, asynchronous to `clk`, active-high.
  - bits 0..9 = digits 0..9.
  - bit 10 = `*`.
  - bit 11 = `#`.
- `wr_en` out 1: one-cycle write strobe to the register file.
- `wr_addr` out 3: register-file slot to write; always equals `ptr`.
- `wr_data` out 7: segment pattern {g,f,e,d,c,b,a}, active-high; 0 whenever `wr_en`=0.
- `out_en` out 1: one-cycle commit pulse on `*`.
- `key_err` out 1: one-cycle pulse when a debounced press is not one-hot.
- `ptr` out 3: current digit pointer.

## Operation
- Input sync: two flops, `key_in` -> `s1` -> `key_s`; both flops reset to 0. The FSM sees only `key_s`.
- FSM states: IDLE, DEB, ACT, WREL. Debounce counter `cnt` is 8 bits wide.
- IDLE:
  - if `key_s`≠0: latch `key_q`<=`key_s`, `cnt`<=0, go to DEB.
- DEB:
  - if `key_s`≠`key_q`: go to IDLE with no action (bounce).
  - else if `cnt`==DEBOUNCE_CYCLES-1: go to ACT.
  - else `cnt`++.
- ACT: lasts exactly one cycle, then go to WREL with `cnt`<=0. Action depends on `key_q`:
  - exactly one of bits 0..9 set: `wr_en`=1, `wr_addr`=`ptr`, `wr_data`=seg(digit). `ptr` unchanged.
  - `key_q`==12'h800 (`#`): `ptr`<=`ptr`+1, modulo 8 (7 wraps to 0). No write.
  - `key_q`==12'h400 (`*`): `out_en`=1.
  - any other value (two or more bits set): `key_err`=1, no other effect.
- WREL:
  - `key_s`≠0 (same key or a different one): `cnt`<=0.
  - `key_s`==0: `cnt`++; when `cnt`==DEBOUNCE_CYCLES-1 go to IDLE.
  - Keys pressed during WREL never cause an action.
- Segment encoding (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66.
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Outputs are registered Moore outputs of the ACT state. At most one of `wr_en`, `out_en`, `key_err` is high in any cycle.

## Timing
- Reset (`rst`=0, asynchronous):
  - state=IDLE, `ptr`=0, `cnt`=0, `key_q`=0, sync flops=0.
  - `wr_en`=`out_en`=`key_err`=0, `wr_data`=0, `wr_addr`=0.
- Reset asserted mid-operation aborts any press in progress: no pulse is produced and `ptr` is not updated.
- Press latency: let `key_in` be stable from before edge k.
  - `key_s` is valid after edge k+1.
  - DEB is entered at edge k+2.
  - ACT is entered at edge k+2+DEBOUNCE_CYCLES.
  - The strobe is high for exactly the following cycle.
- `ptr` update from `#` is visible one cycle after the ACT cycle.
- A digit written in the ACT cycle uses the pre-update `ptr`. No digit and `#` can share an ACT cycle, since only one key is acted on per press.
- Minimum press-to-press spacing: 1 (ACT) + DEBOUNCE_CYCLES (release) + 2 (sync) + DEBOUNCE_CYCLES (press) cycles.
- A glitch shorter than DEBOUNCE_CYCLES samples in DEB returns to IDLE with no action.
- A glitch of that kind in WREL restarts the release count.

## Test plan
- **Reset:** assert `rst`=0 mid-DEB with key 5 held -> all outputs 0 and `ptr`=0; after release of `rst`, no `wr_en` fires until the key has been re-debounced (DEBOUNCE_CYCLES=4).
- **Digit write:** hold key 7 (12'h080) for 20 cycles -> one `wr_en` at cycle k+7 with `wr_addr`=0, `wr_data`=7'h07; then release -> no further pulses.
- **Pointer advance and wrap:** press `#` 8 times, then key 3 -> `ptr` steps 1..7 then 0; the final write has `wr_addr`=0, `wr_data`=7'h4F.
- **Commit:** press `*` -> exactly one `out_en` cycle, no `wr_en`, `ptr` unchanged.
- **Bounce rejection:** toggle bit 2 high 2 cycles, low 1 cycle, repeated 5 times, then hold -> exactly one `wr_en` with `wr_data`=7'h5B.
- **Multi-key:** hold 12'h003 -> one `key_err` pulse, no write. Pressing key 9 while `#` is still held (WREL) -> no action until both are released and re-pressed.
